// File: rtl/instr_fetch_if.sv
// Bundles the instruction-memory bus, the redirect request and the decoder
// handshake of the fetch unit. The master side is the fetch unit itself.
interface instr_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_misaligned_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i,
        output instr_valid_o, instr_o, instr_pc_o, instr_misaligned_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_pc_i,
        input  instr_valid_o, instr_o, instr_pc_o, instr_misaligned_o,
        output instr_ready_i
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited word requests to instruction memory,
// a registered prefetch FIFO of {word, pc}, and redirect/flush handling.
module instr_fetch #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    instr_fetch_if.master bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = 8;

    typedef enum logic {FETCH, FAULT} state_t;

    state_t            state;
    logic [31:0]       fetch_pc;
    logic [31:0]       resp_pc;
    logic [31:0]       fault_pc;
    logic [31:0]       hold_addr;
    logic              hold_valid;
    logic              hold_stale;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard;

    logic [31:0]       fifo_word [FIFO_DEPTH];
    logic [31:0]       fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    fifo_count;

    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              keep;
    logic              grant;
    logic              grant_stale;
    logic              grant_live;
    logic              credit_ok;
    logic [CNT_W:0]    credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop this cycle frees a slot, so steady state sustains one fetch per cycle.
    assign fifo_empty  = (fifo_count == '0);
    assign pop         = (state == FETCH) && !fifo_empty && bus.instr_ready_i;
    assign credit_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(outstanding) - (CNT_W+1)'(pop);
    assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);

    assign bus.imem_req_o  = !rst_i && (hold_valid || ((state == FETCH) && credit_ok));
    assign bus.imem_addr_o = hold_valid ? hold_addr : fetch_pc;

    assign grant       = bus.imem_req_o && bus.imem_gnt_i;
    assign grant_stale = grant && hold_valid && hold_stale;
    assign grant_live  = grant && !(hold_valid && hold_stale);
    assign keep        = bus.imem_rvalid_i && (discard == '0);
    assign push        = !rst_i && !bus.redirect_i && keep;

    assign bus.instr_valid_o      = (state == FAULT) || !fifo_empty;
    assign bus.instr_misaligned_o = (state == FAULT);
    assign bus.instr_o            = ((state == FAULT) || fifo_empty) ? '0 : fifo_word[rd_ptr];
    assign bus.instr_pc_o         = (state == FAULT) ? fault_pc :
                                    fifo_empty       ? '0       : fifo_pc[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_word[wr_ptr] <= bus.imem_rdata_i;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    // A request left ungranted by a redirect is marked stale: its grant is
    // bookkept as a response to discard rather than as a live fetch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= FETCH;
            fetch_pc    <= BOOT_ADDR;
            resp_pc     <= BOOT_ADDR;
            fault_pc    <= '0;
            hold_addr   <= BOOT_ADDR;
            hold_valid  <= 1'b0;
            hold_stale  <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            if (grant) begin
                hold_valid <= 1'b0;
                hold_stale <= 1'b0;
            end else if (bus.imem_req_o) begin
                hold_valid <= 1'b1;
                hold_addr  <= bus.imem_addr_o;
            end

            if (bus.redirect_i) begin
                if (bus.imem_req_o && !grant) begin
                    hold_stale <= 1'b1;
                end
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                fifo_count  <= '0;
                discard     <= discard + outstanding + CNT_W'(grant) - CNT_W'(bus.imem_rvalid_i);
                outstanding <= '0;
                fetch_pc    <= bus.redirect_pc_i;
                resp_pc     <= bus.redirect_pc_i;
                if (bus.redirect_pc_i[1:0] != 2'b00) begin
                    state    <= FAULT;
                    fault_pc <= bus.redirect_pc_i;
                end else begin
                    state    <= FETCH;
                end
            end else begin
                discard     <= discard + CNT_W'(grant_stale)
                               - CNT_W'(bus.imem_rvalid_i && (discard != '0));
                outstanding <= outstanding + CNT_W'(grant_live) - CNT_W'(keep);
                if (grant_live) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr  <= ptr_inc(wr_ptr);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                fifo_count <= fifo_count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a one-cycle-latency in-order memory model
// plus hand-computed expectations for each step.
module tb_instr_fetch;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   mem_hold;
    logic [31:0] pend [$];

    instr_fetch_if bus ();

    instr_fetch #(
        .BOOT_ADDR  (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Drives one cycle of inputs at the falling edge; the memory model answers
    // the oldest grant a cycle later and records any grant made this cycle.
    task automatic apply_stimulus(input logic r, input logic g, input logic rdy,
                                  input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        rst                = r;
        bus.imem_gnt_i     = g;
        bus.instr_ready_i  = rdy;
        bus.redirect_i     = redir;
        bus.redirect_pc_i  = rpc;
        if (r) begin
            pend.delete();
        end
        if (!r && !mem_hold && pend.size() != 0) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = mem_word(pend.pop_front());
        end else begin
            bus.imem_rvalid_i = 1'b0;
            bus.imem_rdata_i  = '0;
        end
        #1;
        if (!r && bus.imem_req_o && g) begin
            pend.push_back(bus.imem_addr_o);
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        errors = 0;
        mem_hold = 1'b0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.instr_ready_i = 1'b0;

        // Reset values
        apply_stimulus(1, 0, 0, 0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 32'h0);
        check_output("rst_req",   32'(bus.imem_req_o), 32'd0);
        check_output("rst_addr",  bus.imem_addr_o, 32'h0);
        check_output("rst_valid", 32'(bus.instr_valid_o), 32'd0);
        check_output("rst_instr", bus.instr_o, 32'h0);
        check_output("rst_pc",    bus.instr_pc_o, 32'h0);
        check_output("rst_mis",   32'(bus.instr_misaligned_o), 32'd0);

        // Streaming: one address per cycle, PCs delivered from cycle 2
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(0, 1, 1, 0, 32'h0);
            check_output("stream_req",  32'(bus.imem_req_o), 32'd1);
            check_output("stream_addr", bus.imem_addr_o, 32'(4 * c));
            if (c >= 2) begin
                check_output("stream_valid", 32'(bus.instr_valid_o), 32'd1);
                check_output("stream_pc",    bus.instr_pc_o, 32'(4 * (c - 2)));
                check_output("stream_instr", bus.instr_o, mem_word(32'(4 * (c - 2))));
            end else begin
                check_output("stream_valid0", 32'(bus.instr_valid_o), 32'd0);
            end
        end

        // Mid-run reset; a redirect while in reset must be ignored
        apply_stimulus(1, 1, 1, 0, 32'h0);
        check_output("mrst_req", 32'(bus.imem_req_o), 32'd0);
        apply_stimulus(1, 1, 1, 1, 32'h102);
        check_output("mrst_valid", 32'(bus.instr_valid_o), 32'd0);
        check_output("mrst_addr",  bus.imem_addr_o, 32'h0);
        check_output("mrst_pc",    bus.instr_pc_o, 32'h0);

        // Decoder stalled: exactly two grants, then requests stop
        apply_stimulus(0, 1, 0, 0, 32'h0);
        check_output("stall_req0",  32'(bus.imem_req_o), 32'd1);
        check_output("stall_addr0", bus.imem_addr_o, 32'h0);
        check_output("stall_mis0",  32'(bus.instr_misaligned_o), 32'd0);
        apply_stimulus(0, 1, 0, 0, 32'h0);
        check_output("stall_addr1", bus.imem_addr_o, 32'h4);
        check_output("stall_valid1", 32'(bus.instr_valid_o), 32'd0);
        apply_stimulus(0, 1, 0, 0, 32'h0);
        check_output("stall_req2", 32'(bus.imem_req_o), 32'd0);
        check_output("stall_pc2",  bus.instr_pc_o, 32'h0);
        apply_stimulus(0, 1, 0, 0, 32'h0);
        check_output("stall_req3",   32'(bus.imem_req_o), 32'd0);
        check_output("stall_instr3", bus.instr_o, mem_word(32'h0));
        apply_stimulus(0, 1, 0, 0, 32'h0);
        check_output("stall_req4",   32'(bus.imem_req_o), 32'd0);
        check_output("stall_valid4", 32'(bus.instr_valid_o), 32'd1);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("stall_req5",  32'(bus.imem_req_o), 32'd1);
        check_output("stall_addr5", bus.imem_addr_o, 32'h8);
        check_output("stall_pc5",   bus.instr_pc_o, 32'h0);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("stall_addr6", bus.imem_addr_o, 32'hC);
        check_output("stall_pc6",   bus.instr_pc_o, 32'h4);

        // Grant withheld for five cycles: request and address hold
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(0, 0, 1, 0, 32'h0);
            check_output("nognt_req",  32'(bus.imem_req_o), 32'd1);
            check_output("nognt_addr", bus.imem_addr_o, 32'h10);
            if (c >= 2) begin
                check_output("nognt_valid", 32'(bus.instr_valid_o), 32'd0);
            end
        end
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("gnt6_addr", bus.imem_addr_o, 32'h10);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("gnt7_addr", bus.imem_addr_o, 32'h14);

        // Redirect to 0x100 with two responses in flight
        mem_hold = 1'b1;
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("inflight_pc",   bus.instr_pc_o, 32'h10);
        check_output("inflight_addr", bus.imem_addr_o, 32'h18);
        apply_stimulus(0, 1, 1, 1, 32'h100);
        check_output("redir_req", 32'(bus.imem_req_o), 32'd0);
        mem_hold = 1'b0;
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("redir_valid1", 32'(bus.instr_valid_o), 32'd0);
        check_output("redir_addr1",  bus.imem_addr_o, 32'h100);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("redir_drop20", 32'(bus.instr_valid_o), 32'd0);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("redir_drop24", 32'(bus.instr_valid_o), 32'd0);
        check_output("redir_req3",   32'(bus.imem_req_o), 32'd0);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("redir_valid4", 32'(bus.instr_valid_o), 32'd1);
        check_output("redir_pc4",    bus.instr_pc_o, 32'h100);
        check_output("redir_instr4", bus.instr_o, mem_word(32'h100));
        check_output("redir_addr4",  bus.imem_addr_o, 32'h108);

        // Redirect coinciding with a response, a pop and a grant: one drop
        apply_stimulus(0, 1, 1, 1, 32'h200);
        check_output("coinc_pc", bus.instr_pc_o, 32'h104);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("coinc_empty", 32'(bus.instr_valid_o), 32'd0);
        check_output("coinc_addr",  bus.imem_addr_o, 32'h200);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("coinc_drop", 32'(bus.instr_valid_o), 32'd0);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("coinc_pc3",    bus.instr_pc_o, 32'h200);
        check_output("coinc_instr3", bus.instr_o, mem_word(32'h200));

        // Misaligned redirect: pending request completes, then fault is held
        apply_stimulus(0, 0, 1, 1, 32'h102);
        check_output("mis_req0",  32'(bus.imem_req_o), 32'd1);
        check_output("mis_addr0", bus.imem_addr_o, 32'h20C);
        apply_stimulus(0, 0, 1, 0, 32'h0);
        check_output("mis_hold_addr", bus.imem_addr_o, 32'h20C);
        check_output("mis_valid", 32'(bus.instr_valid_o), 32'd1);
        check_output("mis_flag",  32'(bus.instr_misaligned_o), 32'd1);
        check_output("mis_pc",    bus.instr_pc_o, 32'h102);
        check_output("mis_instr", bus.instr_o, 32'h0);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("mis_stale_req", 32'(bus.imem_req_o), 32'd1);
        for (int c = 0; c < 2; c++) begin
            apply_stimulus(0, 1, 1, 0, 32'h0);
            check_output("mis_noreq", 32'(bus.imem_req_o), 32'd0);
            check_output("mis_held",  bus.instr_pc_o, 32'h102);
            check_output("mis_flagh", 32'(bus.instr_misaligned_o), 32'd1);
        end
        apply_stimulus(0, 1, 1, 1, 32'h200);
        check_output("mis_exit_req", 32'(bus.imem_req_o), 32'd0);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("resume_mis",   32'(bus.instr_misaligned_o), 32'd0);
        check_output("resume_valid", 32'(bus.instr_valid_o), 32'd0);
        check_output("resume_addr",  bus.imem_addr_o, 32'h200);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("resume_addr1", bus.imem_addr_o, 32'h204);
        apply_stimulus(0, 1, 1, 0, 32'h0);
        check_output("resume_pc",    bus.instr_pc_o, 32'h200);
        check_output("resume_instr", bus.instr_o, mem_word(32'h200));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
